sdram_arbiter: RTL

- Round-robin arbiter that shares the single 16-bit SDRAM access core (addr/read/write/writedata/readdata/finished handshake) between NUM_REQ requesters, such as audio record, audio playback and the UI/loader.
- Sits between the requesters and the SDRAM access core.
- Registers the winning request and holds it stable until the core signals finished.
- Returns read data and a one-cycle done pulse to the winner.

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/sdram_arb_if.sv | 31 +++
 rtl/sdram_arbiter_rr_pick.sv | 28 ++
 rtl/sdram_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM round-robin arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 23;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_arb_if.sv
// Requester-side and access-core-side signal bundle of the SDRAM arbiter.
// Handshake: a requester raises read/write with addr/writedata stable and holds them until its done bit pulses; readdata is valid with done. Toward the core, read/write stay high and stable until finished pulses for one cycle.
interface sdram_arb_if import sdram_arb_pkg::*; #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) ();
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_writedata;
    logic [DATA_W-1:0]         req_readdata;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        grant;
    logic [ADDR_W-1:0]         sdram_addr;
    logic                      sdram_read;
    logic                      sdram_write;
    logic [DATA_W-1:0]         sdram_writedata;
    logic [DATA_W-1:0]         sdram_readdata;
    logic                      sdram_finished;

    modport slave (
        input  req_addr, req_read, req_write, req_writedata, sdram_readdata, sdram_finished,
        output req_readdata, req_done, grant, sdram_addr, sdram_read, sdram_write, sdram_writedata
    );

    modport master (
        output req_addr, req_read, req_write, req_writedata, sdram_readdata, sdram_finished,
        input  req_readdata, req_done, grant, sdram_addr, sdram_read, sdram_write, sdram_writedata
    );
endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending bit after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          valid
);
    logic [IW-1:0] cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        valid   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!valid && pend[cand]) begin
                valid         = 1'b1;
                win_idx       = cand;
                win_oh[cand]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM access core among NUM_REQ requesters.
// Optional SDRAM_ARB_PRIO0_EN gives requester 0 strict priority over the round robin.
module sdram_arbiter import sdram_arb_pkg::*; #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    sdram_arb_if.slave   bus,
    output state_t       fsm_state
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;

    logic [NUM_REQ-1:0]  pend, rr_pend, rr_oh, win_oh;
    logic [IDX_W-1:0]    rr_idx, win_idx;
    logic                rr_valid, win_valid, win_upd;

    assign pend = bus.req_read | bus.req_write;

`ifdef SDRAM_ARB_PRIO0_EN
    // Requester 0 bypasses the pointer; the others rotate among themselves.
    assign rr_pend = {pend[NUM_REQ-1:1], 1'b0};
    always_comb begin
        win_oh    = rr_oh;
        win_idx   = rr_idx;
        win_valid = rr_valid;
        win_upd   = 1'b1;
        if (pend[0]) begin
            win_oh    = NUM_REQ'(1);
            win_idx   = '0;
            win_valid = 1'b1;
            win_upd   = 1'b0;
        end
    end
`else
    assign rr_pend   = pend;
    assign win_oh    = rr_oh;
    assign win_idx   = rr_idx;
    assign win_valid = rr_valid;
    assign win_upd   = 1'b1;
`endif

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .pend    (rr_pend),
        .ptr     (ptr_q),
        .win_oh  (rr_oh),
        .win_idx (rr_idx),
        .valid   (rr_valid)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        grant_d = grant_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    addr_d  = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_d = bus.req_writedata[int'(win_idx)*DATA_W +: DATA_W];
                    wr_d    = bus.req_write[win_idx];
                    rd_d    = bus.req_read[win_idx] & ~bus.req_write[win_idx];
                    grant_d = win_oh;
                    if (win_upd) ptr_d = win_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.sdram_finished) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) rdata_d = bus.sdram_readdata;
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end
            end
            // The winner may still hold its request here, so nothing is sampled.
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign bus.req_readdata    = rdata_q;
    assign bus.req_done        = done_q;
    assign bus.grant           = grant_q;
    assign bus.sdram_addr      = addr_q;
    assign bus.sdram_read      = rd_q;
    assign bus.sdram_write     = wr_q;
    assign bus.sdram_writedata = wdata_q;
    assign fsm_state           = state_q;
endmodule
